// File: rtl/cyclic_encoder74_pkg.sv
// Shared definitions for the (7,4) cyclic encoder.
//   - Code geometry constants N, K and R.
//   - Default generator low coefficients for g(x) = x^3 + x + 1.
//   - FSM state encoding. It is used by the top and by any bench that
//     watches the debug state port.
package cyclic_encoder74_pkg;

  localparam int N = 7;  // codeword length
  localparam int K = 4;  // message length
  localparam int R = 3;  // parity length, degree of g(x)

  // Low coefficients of g(x). The x^3 term is implicit.
  localparam logic [R-1:0] GPOLY_DEFAULT = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cyc_state_e;

endpackage

// File: rtl/cyc_lfsr_div.sv
// Divide-by-g(x) LFSR that computes the remainder of m(x)*x^3 mod g(x).
// Message bits enter high-order first. The x^3 pre-multiply comes from
// injecting the input at the feedback point instead of at s0.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset; clears the remainder
//   clr    in   synchronous clear; takes priority over en
//   en     in   shift one input bit this cycle
//   din    in   message bit
//   rem    out  current remainder {s2, s1, s0}
module cyc_lfsr_div
  import cyclic_encoder74_pkg::*;
#(
  parameter logic [R-1:0] GPOLY = GPOLY_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         din,
  output logic [R-1:0] rem
);

  logic [R-1:0] rem_q;
  logic [R-1:0] rem_d;
  logic         fb;

  // The default GPOLY gives fb=in^s2; s2<=s1; s1<=s0^fb; s0<=fb.
  always_comb begin
    fb    = din ^ rem_q[2];
    rem_d = rem_q;
    if (clr) begin
      rem_d = '0;
    end else if (en) begin
      rem_d[2] = rem_q[1] ^ (fb & GPOLY[2]);
      rem_d[1] = rem_q[0] ^ (fb & GPOLY[1]);
      rem_d[0] = fb & GPOLY[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
    end else begin
      rem_q <= rem_d;
    end
  end

  assign rem = rem_q;

endmodule

// File: rtl/cyclic_encoder74.sv
// Systematic (7,4) cyclic encoder.
// The encoder accepts a 4-bit message and spends 7 SHIFT cycles computing
// the parity. It then presents c = {m, remainder} until downstream takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data stable while valid is high and
// ready is low. m_ready is high only in IDLE. c_valid stays high, with c
// stable, until c_ready is sampled high.
//
// Optional feature: define CYC_ENC_SERIAL_OUT_EN to drive ser_out/ser_valid
// with the codeword, high-order bit first, one bit per SHIFT cycle. When the
// macro is undefined, both ports are tied low.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   m[3:0]       in   message, m[3] is the highest-order term
//   m_valid      in   message offered
//   m_ready      out  encoder idle and able to accept
//   c[6:0]       out  codeword, c[6] is the highest-order term
//   c_valid      out  c holds a complete codeword
//   c_ready      in   downstream consumes c
//   ser_out      out  serial codeword bit (optional feature)
//   ser_valid    out  qualifier for ser_out (optional feature)
//   dbg_state_o  out  current FSM state, for observation
module cyclic_encoder74
  import cyclic_encoder74_pkg::*;
#(
  parameter logic [R-1:0] GPOLY = GPOLY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [K-1:0]     m,
  input  logic             m_valid,
  output logic             m_ready,
  output logic [N-1:0]     c,
  output logic             c_valid,
  input  logic             c_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output cyc_state_e       dbg_state_o
);

  cyc_state_e   state_q;
  logic [2:0]   k_q;
  logic [K-1:0] m_q;
  logic [N-1:0] c_q;
  logic         c_valid_q;

  logic [R-1:0] rem;
  logic         lfsr_clr;
  logic         lfsr_en;
  logic         lfsr_din;

  // Message bit m[3-k]. Only k = 0..3 reaches the LFSR, so k[1:0] is enough.
  assign lfsr_clr = (state_q == IDLE) && m_valid;
  assign lfsr_en  = (state_q == SHIFT) && (k_q < 3'd4);
  assign lfsr_din = m_q[2'd3 - k_q[1:0]];

  cyc_lfsr_div #(
    .GPOLY (GPOLY)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (lfsr_clr),
    .en    (lfsr_en),
    .din   (lfsr_din),
    .rem   (rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      m_q       <= '0;
      c_q       <= '0;
      c_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_valid) begin
            m_q     <= m;
            k_q     <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // The remainder is final after k=3. On the last SHIFT edge it is
          // still held, so it can be captured directly.
          if (k_q == 3'd6) begin
            c_q       <= {m_q, rem};
            c_valid_q <= 1'b1;
            k_q       <= '0;
            state_q   <= DONE;
          end else begin
            k_q <= k_q + 3'd1;
          end
        end
        DONE: begin
          if (c_ready) begin
            c_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_ready     = (state_q == IDLE);
  assign c           = c_q;
  assign c_valid     = c_valid_q;
  assign dbg_state_o = state_q;

`ifdef CYC_ENC_SERIAL_OUT_EN
  // Cycle k carries c[6-k]. For k = 0..3 that bit is m[3-k]. For k = 4..6 it
  // is rem[6-k], and k[1:0] = 0,1,2 maps to rem index 2,1,0.
  logic ser_bit;
  always_comb begin
    ser_bit = 1'b0;
    if (k_q < 3'd4) begin
      ser_bit = m_q[2'd3 - k_q[1:0]];
    end else begin
      ser_bit = rem[2'd2 - k_q[1:0]];
    end
  end
  assign ser_valid = (state_q == SHIFT);
  assign ser_out   = ser_valid & ser_bit;
`else
  assign ser_valid = 1'b0;
  assign ser_out   = 1'b0;
`endif

endmodule

// File: tb/tb_cyclic_encoder74.sv
// Bench for cyclic_encoder74. Directed steps are followed by a sweep of all
// 16 messages with random c_ready stalls. Expected codewords come from a
// long-division reference and are queued at acceptance, then compared when
// the codeword is consumed.
module tb_cyclic_encoder74;
  import cyclic_encoder74_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] m = '0;
  logic       m_valid = 1'b0;
  logic       m_ready;
  logic [6:0] c;
  logic       c_valid;
  logic       c_ready = 1'b0;
  logic       ser_out;
  logic       ser_valid;
  cyc_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  cyclic_encoder74 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m           (m),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .c           (c),
    .c_valid     (c_valid),
    .c_ready     (c_ready),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  // Polynomial long division of a 7-bit word by g(x); returns the remainder.
  function automatic logic [2:0] poly_mod(input logic [6:0] w);
    logic [6:0] v;
    logic [6:0] g;
    v = w;
    g = {3'b000, 1'b1, GPOLY_DEFAULT};
    for (int i = 6; i >= 3; i--) begin
      if (v[i]) v = v ^ (g << (i - 3));
    end
    return v[2:0];
  endfunction

  function automatic logic [6:0] ref_enc(input logic [3:0] mv);
    return {mv, poly_mod({mv, 3'b000})};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Offer mv, follow it through SHIFT, stall c_ready for 'hold' cycles and
  // then consume. With 'poke' set, a different message is offered during
  // SHIFT and DONE; the encoder must ignore it.
  task automatic encode_one(input logic [3:0] mv, input int hold, input bit poke);
    logic [6:0] e;
    logic [6:0] got;
    e = ref_enc(mv);
    check("m_ready_idle", 32'(m_ready), 32'd1);
    m = mv;
    m_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    if (poke) m = ~mv;
    else m_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      check("m_ready_shift", 32'(m_ready), 32'd0);
      check("c_valid_early", 32'(c_valid), 32'd0);
`ifdef CYC_ENC_SERIAL_OUT_EN
      check("ser_valid", 32'(ser_valid), 32'd1);
      check("ser_out", 32'(ser_out), 32'(e[6-k]));
`else
      check("ser_valid_off", 32'(ser_valid), 32'd0);
      check("ser_out_off", 32'(ser_out), 32'd0);
`endif
      if (k == 5) m_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    check("c_valid_latency", 32'(c_valid), 32'd1);
    check("ser_valid_done", 32'(ser_valid), 32'd0);
    for (int h = 0; h < hold; h++) begin
      if (poke) begin
        m = ~mv;
        m_valid = 1'b1;
      end
      check("c_hold", 32'(c), 32'(e));
      check("c_valid_hold", 32'(c_valid), 32'd1);
      check("m_ready_done", 32'(m_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    m_valid = 1'b0;
    c_ready = 1'b1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0x%0h expected=queued_entry", c);
    end else begin
      got = exp_q.pop_front();
      check("codeword", 32'(c), 32'(got));
      check("syndrome", 32'(poly_mod(c)), 32'd0);
    end
    @(posedge clk);
    #1;
    c_ready = 1'b0;
    check("c_valid_clear", 32'(c_valid), 32'd0);
    check("m_ready_back", 32'(m_ready), 32'd1);
    check("state_idle", 32'(dbg_state), 32'(IDLE));
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c", 32'(c), 32'd0);
    check("rst_c_valid", 32'(c_valid), 32'd0);
    check("rst_m_ready", 32'(m_ready), 32'd1);
    check("rst_ser_out", 32'(ser_out), 32'd0);
    check("rst_ser_valid", 32'(ser_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors, back to back, with hand-derived codewords
    check("ref_1000", 32'(ref_enc(4'b1000)), 32'(7'b1000101));
    encode_one(4'b1000, 0, 1'b0);
    encode_one(4'b0001, 0, 1'b0);
    encode_one(4'b1111, 0, 1'b0);
    encode_one(4'b0000, 0, 1'b0);
    // Stall 5 cycles while a competing message is offered
    encode_one(4'b1010, 5, 1'b1);

    // Reset in the middle of SHIFT (k=3)
    m = 4'b0110;
    m_valid = 1'b1;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_state", 32'(dbg_state), 32'(SHIFT));
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    check("arst_c", 32'(c), 32'd0);
    check("arst_c_valid", 32'(c_valid), 32'd0);
    check("arst_ser_out", 32'(ser_out), 32'd0);
    check("arst_ser_valid", 32'(ser_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    encode_one(4'b0001, 0, 1'b0);

    // All 16 messages with random downstream stalls
    for (int i = 0; i < 16; i++) begin
      encode_one(4'(i), int'($urandom_range(0, 3)), 1'b0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
